// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART constants, the one-hot receiver state encoding and
//             the default bit period used by both the receiver and transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Payload width of one 8N1 character.
  localparam int DATA_BITS = 8;

  // 100 MHz / 115200 baud, shared with the transmitter.
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // One-hot receiver state encoding.
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_START = 5'b00010;
  localparam logic [4:0] ST_DATA  = 5'b00100;
  localparam logic [4:0] ST_STOP  = 5'b01000;
  localparam logic [4:0] ST_BREAK = 5'b10000;

  typedef enum logic [4:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync2
//  Brief    : Two-flop synchroniser for a single asynchronous input, with a
//             selectable reset value so idle-high lines do not glitch low.
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resynchronisation of the asynchronous input into CLK100MHZ.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver with start-glitch rejection, framing/overrun
//             reporting and a valid/ready byte output.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 UART_TXD_IN,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start.
  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .d         (UART_TXD_IN),
    .q         (rxs)
  );

  // Receive FSM with registered outputs; baud counter is cleared on every state entry.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A completed handshake drops valid unless a new byte loads below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rxs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // Re-check the line at the start-bit centre to reject short glitches.
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // Sample each data bit at its centre, LSB first.
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // Leave at mid-stop-bit so the next start edge is not missed.
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        // A held-low line is a break; wait for it to return high.
        BREAK: begin
          baud_cnt <= '0;
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx: table of single frames plus
//             directed glitch, break, overrun, reset and loopback sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  // Shortened bit period keeps the run brief; all timing scales from it.
  localparam int CPB  = 96;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       CLK100MHZ = 1'b0;
  logic       reset     = 1'b1;
  logic       line      = 1'b1;
  logic       rx_ready  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 CLK100MHZ = ~CLK100MHZ;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset       (reset),
    .UART_TXD_IN (line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [7:0] rcv [$];
  int         rise_cyc  = 0;
  int         valid_hi  = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         stab_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge CLK100MHZ) begin
    prev_valid <= rx_valid;
    prev_data  <= rx_data;
    prev_xfer  <= rx_valid && rx_ready;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (rx_valid) valid_hi <= valid_hi + 1;
    if (rx_valid && rx_ready) rcv.push_back(rx_data);
    if (rx_valid && prev_valid && !prev_xfer && (rx_data != prev_data))
      stab_viol <= stab_viol + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    total++;
    if ((act < exp - tol) || (act > exp + tol)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // Serialise one 8N1 character; c0 is the cycle on which the start edge is driven.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int c0);
    c0   = cyc;
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick(CPB);
    end
    line = stop_bit;
    tick(CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] lb   [16];

  initial begin
    int c0, b_rcv, b_f, b_o, b_vh, busy_low;
    logic done;

    vecs[0] = '{8'hAF, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};
    vecs[6] = '{8'h7E, 1'b0, 0, 1};

    // Reset state.
    @(negedge CLK100MHZ);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset rx_data", int'(rx_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    tick(1);
    reset = 1'b0;
    tick(10);

    // Single frames from the table, consumer always ready.
    rx_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      b_rcv = rcv.size(); b_f = ferr_cnt; b_o = ovr_cnt; b_vh = valid_hi;
      send_frame(vecs[v].data, vecs[v].stop_bit, c0);
      line = 1'b1;
      tick(20);
      check($sformatf("vec%0d bytes", v), rcv.size() - b_rcv, vecs[v].exp_bytes);
      if (rcv.size() > b_rcv) begin
        check($sformatf("vec%0d data", v), int'(rcv[b_rcv]), int'(vecs[v].data));
        check_near($sformatf("vec%0d latency", v), rise_cyc - c0 - 1, LAT, 3);
        check($sformatf("vec%0d valid width", v), valid_hi - b_vh, 1);
      end
      check($sformatf("vec%0d frame_err", v), ferr_cnt - b_f, vecs[v].exp_ferr);
      check($sformatf("vec%0d overrun", v), ovr_cnt - b_o, 0);
      check($sformatf("vec%0d busy idle", v), int'(busy), 0);
    end

    // Start-bit glitch shorter than half a bit.
    b_rcv = rcv.size(); b_f = ferr_cnt;
    line = 1'b0;
    tick(HALF / 2);
    line = 1'b1;
    begin
      int waited = HALF / 2;
      while (busy && waited < HALF + 4) begin
        tick(1);
        waited++;
      end
    end
    check("glitch busy cleared", int'(busy), 0);
    tick(CPB * 10);
    check("glitch bytes", rcv.size() - b_rcv, 0);
    check("glitch frame_err", ferr_cnt - b_f, 0);
    check("glitch busy idle", int'(busy), 0);

    // Bad stop bit followed by a held-low break, then a good frame.
    b_rcv = rcv.size(); b_f = ferr_cnt;
    send_frame(8'h55, 1'b0, c0);
    busy_low = 0;
    for (int i = 0; i < 4 * CPB; i++) begin
      if (!busy) busy_low++;
      tick(1);
    end
    check("break busy held", busy_low, 0);
    check("break bytes", rcv.size() - b_rcv, 0);
    line = 1'b1;
    tick(10);
    check("break busy released", int'(busy), 0);
    check("break frame_err", ferr_cnt - b_f, 1);
    send_frame(8'h3C, 1'b1, c0);
    tick(20);
    check("after break bytes", rcv.size() - b_rcv, 1);
    if (rcv.size() > b_rcv) check("after break data", int'(rcv[b_rcv]), 8'h3C);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    b_rcv = rcv.size(); b_o = ovr_cnt;
    send_frame(8'h12, 1'b1, c0);
    send_frame(8'h34, 1'b1, c0);
    tick(20);
    check("overrun pulses", ovr_cnt - b_o, 1);
    check("overrun rx_valid", int'(rx_valid), 1);
    check("overrun rx_data", int'(rx_data), 8'h12);
    check("overrun no xfer", rcv.size() - b_rcv, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(3);
    check("overrun xfer count", rcv.size() - b_rcv, 1);
    if (rcv.size() > b_rcv) check("overrun xfer data", int'(rcv[b_rcv]), 8'h12);
    check("overrun valid dropped", int'(rx_valid), 0);

    // Reset in the middle of data bit 4 of 0x81.
    rx_ready = 1'b1;
    b_rcv = rcv.size(); b_f = ferr_cnt;
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      line = (8'h81 >> i) & 1;
      tick(CPB);
    end
    line = 1'b0;
    tick(HALF);
    reset = 1'b1;
    line  = 1'b1;
    @(negedge CLK100MHZ);
    check("midreset rx_valid", int'(rx_valid), 0);
    check("midreset rx_data", int'(rx_data), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset frame_err", int'(frame_err), 0);
    check("midreset overrun", int'(overrun), 0);
    tick(3);
    reset = 1'b0;
    tick(2 * CPB);
    check("midreset no delivery", rcv.size() - b_rcv, 0);
    send_frame(8'hC3, 1'b1, c0);
    tick(20);
    check("midreset next bytes", rcv.size() - b_rcv, 1);
    if (rcv.size() > b_rcv) check("midreset next data", int'(rcv[b_rcv]), 8'hC3);
    check("midreset frame_err", ferr_cnt - b_f, 0);

    // Back-to-back transmitter stream with a randomly stalling consumer.
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'hA5;
    for (int i = 3; i < 16; i++) lb[i] = 8'(8'h10 + i);
    b_rcv = rcv.size(); b_f = ferr_cnt; b_o = ovr_cnt;
    done = 1'b0;
    fork
      begin
        int c1;
        for (int i = 0; i < 16; i++) send_frame(lb[i], 1'b1, c1);
        tick(20);
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    rx_ready = 1'b1;
    tick(5);
    check("loopback bytes", rcv.size() - b_rcv, 16);
    for (int i = 0; i < 16; i++) begin
      if (b_rcv + i < rcv.size())
        check($sformatf("loopback byte%0d", i), int'(rcv[b_rcv + i]), int'(lb[i]));
    end
    check("loopback frame_err", ferr_cnt - b_f, 0);
    check("loopback overrun", ovr_cnt - b_o, 0);

    check("rx_data stable while valid", stab_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_rx
`default_nettype wire
